// File: rtl/flp_spi_pkg.sv
// Shared frame constants and FSM state encoding for the FLP SPI slave
// and the SPICore32 master that talks to it.
package flp_spi_pkg;
  localparam int FRAME_W = 32;
  localparam int CMD_W   = 8;
  localparam int DATA_W  = 24;
  localparam int REG_CNT = 16;
  localparam int ADDR_W  = 4;
  localparam int CNT_W   = 6;

  typedef enum logic [2:0] {
    ST_WAIT,
    ST_IDLE,
    ST_CMD,
    ST_DATA,
    ST_OVER
  } state_t;
endpackage

// File: rtl/flp_sync_bit.sv
// Multi-flop synchronizer for one asynchronous input bit, with a
// selectable reset value so idle-high lines come out of reset idle.
module flp_sync_bit #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ff <= {STAGES{RST_VAL}};
    end else begin
      for (int i = STAGES - 1; i > 0; i--) ff[i] <= ff[i-1];
      ff[0] <= d;
    end
  end

  assign q = ff[STAGES-1];
endmodule

// File: rtl/flp_spi_slave32.sv
// SPI mode-0 slave with 32-bit frames (rnw, 7-bit addr, 24-bit data)
// backed by a 16 x 24-bit register file, oversampled on CLK.
module flp_spi_slave32
  import flp_spi_pkg::*;
#(
  parameter int                SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] REG_INIT    = 24'h000000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              spi_sclk,
  input  logic              spi_csb,
  input  logic              spi_sdi,
  output logic              spi_sdo,
  output logic              spi_sdo_oe,
  output logic              wr_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              frame_err,
  input  logic [ADDR_W-1:0] reg_rd_addr,
  output logic [DATA_W-1:0] reg_rd_data,
  output state_t            dbg_state
);
  // wr_valid and frame_err are single-CLK event pulses with no ready/backpressure:
  // the consumer must sample them on the cycle they are high.

  logic sclk_s, csb_s, sdi_s;
  logic sclk_d, csb_d;
  logic sclk_rise, sclk_fall, csb_rise, csb_fall;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt;
  logic [FRAME_W-1:0] sh;
  logic [DATA_W-1:0]  out_sh;
  logic               rd_q;
  logic               overrun;
  logic [7:0]         warm_cnt;
  logic               warm_done;
  logic [DATA_W-1:0]  regs [REG_CNT];

  flp_sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(CLK), .rst(RST), .d(spi_sclk), .q(sclk_s)
  );
  flp_sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_csb (
    .clk(CLK), .rst(RST), .d(spi_csb), .q(csb_s)
  );
  flp_sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sdi (
    .clk(CLK), .rst(RST), .d(spi_sdi), .q(sdi_s)
  );

  // csb edges take priority: an sclk edge in the same CLK as a csb rise is dropped.
  assign csb_rise  = csb_s & ~csb_d;
  assign csb_fall  = ~csb_s & csb_d;
  assign sclk_rise = sclk_s & ~sclk_d & ~csb_rise;
  assign sclk_fall = ~sclk_s & sclk_d & ~csb_rise;

  // The synchronizers come out of reset reading csb high; wait until the
  // real pin value has flushed through before trusting csb to leave WAIT.
  assign warm_done = (warm_cnt == 8'(SYNC_STAGES + 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= ST_WAIT;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_WAIT: if (warm_done && csb_s) state_nx = ST_IDLE;
      ST_IDLE: if (csb_fall) state_nx = ST_CMD;
      ST_CMD: begin
        if (csb_rise) state_nx = ST_IDLE;
        else if (sclk_rise && cnt == CNT_W'(CMD_W - 1)) state_nx = ST_DATA;
      end
      ST_DATA: begin
        if (csb_rise) state_nx = ST_IDLE;
        else if (sclk_rise && cnt == CNT_W'(FRAME_W - 1)) state_nx = ST_OVER;
      end
      ST_OVER: if (csb_rise) state_nx = ST_IDLE;
      default: state_nx = ST_WAIT;
    endcase
  end

  always_comb begin
    spi_sdo_oe  = (state == ST_DATA) && rd_q;
    spi_sdo     = spi_sdo_oe & out_sh[DATA_W-1];
    reg_rd_data = regs[reg_rd_addr];
    dbg_state   = state;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sclk_d    <= 1'b0;
      csb_d     <= 1'b1;
      cnt       <= '0;
      sh        <= '0;
      out_sh    <= '0;
      rd_q      <= 1'b0;
      overrun   <= 1'b0;
      warm_cnt  <= '0;
      wr_valid  <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      frame_err <= 1'b0;
      for (int i = 0; i < REG_CNT; i++) regs[i] <= REG_INIT;
    end else begin
      sclk_d    <= sclk_s;
      csb_d     <= csb_s;
      wr_valid  <= 1'b0;
      frame_err <= 1'b0;
      if (state == ST_WAIT && !warm_done) warm_cnt <= warm_cnt + 8'd1;

      case (state)
        ST_IDLE: begin
          if (csb_fall) begin
            cnt     <= '0;
            sh      <= '0;
            overrun <= 1'b0;
            rd_q    <= 1'b0;
          end
        end
        ST_CMD: begin
          if (csb_rise) begin
            frame_err <= 1'b1;
          end else if (sclk_rise) begin
            sh  <= {sh[FRAME_W-2:0], sdi_s};
            cnt <= cnt + CNT_W'(1);
            // Last command bit: {sh[6:0], sdi_s} is the full rnw/addr byte.
            if (cnt == CNT_W'(CMD_W - 1)) begin
              rd_q   <= sh[6];
              out_sh <= (sh[6] && sh[5:3] == 3'b000) ? regs[{sh[2:0], sdi_s}] : '0;
            end
          end
        end
        ST_DATA: begin
          if (csb_rise) begin
            frame_err <= 1'b1;
          end else if (sclk_rise) begin
            sh  <= {sh[FRAME_W-2:0], sdi_s};
            cnt <= cnt + CNT_W'(1);
          end else if (sclk_fall && cnt >= CNT_W'(CMD_W + 1)) begin
            // Bit 23 must stay up through the first data rise, so the first fall is skipped.
            out_sh <= {out_sh[DATA_W-2:0], 1'b0};
          end
        end
        ST_OVER: begin
          if (csb_rise) begin
            if (overrun) begin
              frame_err <= 1'b1;
            end else if (!sh[31] && sh[30:28] == 3'b000) begin
              regs[sh[27:24]] <= sh[DATA_W-1:0];
              wr_valid        <= 1'b1;
              wr_addr         <= sh[27:24];
              wr_data         <= sh[DATA_W-1:0];
            end
          end else if (sclk_rise) begin
            overrun <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_flp_spi_slave32.sv
// Directed bench for flp_spi_slave32: a bit-banged mode-0 master at
// sclk = CLK/10 plus a pulse monitor on the host-side outputs.
module tb_flp_spi_slave32;
  import flp_spi_pkg::*;

  localparam logic [23:0] INIT = 24'hC0FFEE;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        spi_sclk = 1'b0;
  logic        spi_csb = 1'b1;
  logic        spi_sdi = 1'b0;
  logic        spi_sdo, spi_sdo_oe, wr_valid, frame_err;
  logic [3:0]  wr_addr;
  logic [23:0] wr_data;
  logic [3:0]  reg_rd_addr = 4'h0;
  logic [23:0] reg_rd_data;
  state_t      dbg_state;

  int n_checks = 0;
  int n_fail = 0;

  // Monitor state (written only by the monitor process).
  int          wr_cnt = 0, wr_hi = 0, err_cnt = 0;
  logic        wr_prev = 1'b0;
  logic [3:0]  last_addr = 4'h0;
  logic [23:0] last_data = 24'h0, post_rd = 24'h0;

  // Master-side capture (written only by the main process).
  logic [23:0] rx_sh;
  int          oe_rises;
  int          b_wr, b_hi, b_err;

  flp_spi_slave32 #(.SYNC_STAGES(2), .REG_INIT(INIT)) dut (
    .CLK(CLK), .RST(RST),
    .spi_sclk(spi_sclk), .spi_csb(spi_csb), .spi_sdi(spi_sdi),
    .spi_sdo(spi_sdo), .spi_sdo_oe(spi_sdo_oe),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_err(frame_err),
    .reg_rd_addr(reg_rd_addr), .reg_rd_data(reg_rd_data),
    .dbg_state(dbg_state)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (wr_valid && !wr_prev) begin
      wr_cnt    <= wr_cnt + 1;
      last_addr <= wr_addr;
      last_data <= wr_data;
    end
    if (wr_valid) wr_hi <= wr_hi + 1;
    if (wr_prev) post_rd <= reg_rd_data;
    if (frame_err) err_cnt <= err_cnt + 1;
    wr_prev <= wr_valid;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic snap();
    b_wr = wr_cnt;
    b_hi = wr_hi;
    b_err = err_cnt;
    rx_sh = 24'h0;
    oe_rises = 0;
  endtask

  // One sclk period: present data, wait half, sample slave output at the rise.
  task automatic clk_bit(input logic b, input bit sample);
    spi_sdi = b;
    wait_clk(5);
    if (spi_sdo_oe) oe_rises++;
    if (sample) rx_sh = {rx_sh[22:0], spi_sdo};
    spi_sclk = 1'b1;
    wait_clk(5);
    spi_sclk = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] frame, input int nbits);
    spi_csb = 1'b0;
    wait_clk(5);
    for (int i = 0; i < nbits; i++)
      clk_bit((i < 32) ? frame[31-i] : 1'b0, (i >= 8 && i < 32));
    wait_clk(5);
    spi_csb = 1'b1;
    wait_clk(20);
  endtask

  task automatic read_reg(input logic [3:0] a, output logic [23:0] v);
    @(negedge CLK);
    reg_rd_addr = a;
    #1;
    v = reg_rd_data;
  endtask

  initial begin
    logic [23:0] v;
    logic [31:0] f;

    // Reset values while RST is held.
    wait_clk(3);
    check("rst_sdo", 32'(spi_sdo), 32'h0);
    check("rst_oe", 32'(spi_sdo_oe), 32'h0);
    check("rst_wr_valid", 32'(wr_valid), 32'h0);
    check("rst_frame_err", 32'(frame_err), 32'h0);
    check("rst_wr_addr", 32'(wr_addr), 32'h0);
    check("rst_wr_data", 32'(wr_data), 32'h0);
    check("rst_state", 32'(dbg_state), 32'(ST_WAIT));
    read_reg(4'h9, v);
    check("rst_reg9", 32'(v), 32'(INIT));
    RST = 1'b0;
    wait_clk(10);
    check("idle_after_rst", 32'(dbg_state), 32'(ST_IDLE));

    // Plain write to addr 3.
    snap();
    reg_rd_addr = 4'h3;
    send_frame(32'h03A5A5A5, 32);
    check("wr_pulses", 32'(wr_cnt - b_wr), 32'd1);
    check("wr_pulse_width", 32'(wr_hi - b_hi), 32'd1);
    check("wr_addr", 32'(last_addr), 32'h3);
    check("wr_data", 32'(last_data), 32'hA5A5A5);
    check("wr_rd_next_clk", 32'(post_rd), 32'hA5A5A5);
    check("wr_no_err", 32'(err_cnt - b_err), 32'd0);

    // Read back addr 3, then an untouched register.
    snap();
    send_frame(32'h83000000, 32);
    check("rd3_data", 32'(rx_sh), 32'hA5A5A5);
    check("rd3_oe_periods", 32'(oe_rises), 32'd24);
    check("rd3_no_wr", 32'(wr_cnt - b_wr), 32'd0);
    check("rd3_no_err", 32'(err_cnt - b_err), 32'd0);
    snap();
    send_frame(32'h85000000, 32);
    check("rd5_init", 32'(rx_sh), 32'(INIT));
    read_reg(4'h3, v);
    check("rd_no_change", 32'(v), 32'hA5A5A5);

    // Short frame: 31 bits.
    snap();
    send_frame(32'h05111111, 31);
    check("short_err", 32'(err_cnt - b_err), 32'd1);
    check("short_no_wr", 32'(wr_cnt - b_wr), 32'd0);
    read_reg(4'h5, v);
    check("short_reg5", 32'(v), 32'(INIT));
    snap();
    send_frame(32'h05222222, 32);
    check("after_short_wr", 32'(wr_cnt - b_wr), 32'd1);
    read_reg(4'h5, v);
    check("after_short_reg5", 32'(v), 32'h222222);

    // Long frame: 33 bits.
    snap();
    send_frame(32'h06333333, 33);
    check("long_err", 32'(err_cnt - b_err), 32'd1);
    check("long_no_wr", 32'(wr_cnt - b_wr), 32'd0);
    read_reg(4'h6, v);
    check("long_reg6", 32'(v), 32'(INIT));

    // Out-of-range address 7'h20.
    snap();
    send_frame(32'h20123456, 32);
    check("oor_no_wr", 32'(wr_cnt - b_wr), 32'd0);
    read_reg(4'h0, v);
    check("oor_reg0", 32'(v), 32'(INIT));
    snap();
    send_frame(32'hA0000000, 32);
    check("oor_rd_zero", 32'(rx_sh), 32'h0);
    check("oor_rd_oe", 32'(oe_rises), 32'd24);

    // Reset at frame bit 12 with csb still low, then finish the frame.
    snap();
    f = 32'h07ABCDEF;
    spi_csb = 1'b0;
    wait_clk(5);
    for (int i = 0; i < 12; i++) clk_bit(f[31-i], 1'b0);
    RST = 1'b1;
    wait_clk(3);
    check("mid_rst_state", 32'(dbg_state), 32'(ST_WAIT));
    RST = 1'b0;
    for (int i = 12; i < 32; i++) clk_bit(f[31-i], 1'b0);
    wait_clk(5);
    spi_csb = 1'b1;
    wait_clk(20);
    check("mid_rst_no_wr", 32'(wr_cnt - b_wr), 32'd0);
    check("mid_rst_no_err", 32'(err_cnt - b_err), 32'd0);
    for (int a = 0; a < 16; a++) begin
      read_reg(4'(a), v);
      check($sformatf("mid_rst_reg%0d", a), 32'(v), 32'(INIT));
    end
    snap();
    send_frame(32'h07ABCDEF, 32);
    check("post_rst_wr", 32'(wr_cnt - b_wr), 32'd1);
    read_reg(4'h7, v);
    check("post_rst_reg7", 32'(v), 32'hABCDEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
